exec_stage: RTL and testbench
=============================

# exec_stage

Parametrised execute stage for the mspu core pipeline, sitting between decode and memory access. It computes ALU results and branch/jump targets. It replaces the fixed run/stall interface with a valid/ready handshake on both sides, and replaces the fixed two-cycle redirect stall with a configurable flush window. An optional iterative multiply unit is selected per instruction.

## Interface
- XLEN, 32: datapath width for operands, pc, immediates, results and addresses.
- FLUSH_CYCLES, 2: cycles in_ready is held low after a redirect is issued; 0..7.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid / in_ready  in / out  1 / 1  upstream handshake.
- alu_op  in  4  ALU op code (exec_pkg encoding); selects MUL/MULHU when muldiv_en=1.
- alu_a, alu_b, pc, imm_value  in  XLEN each  operands.
- branch_en, jal_en, jalr_en, unsigned_flag, muldiv_en  in  1 each  instruction class flags.
- mem_to_reg_in, bytes_in[1:0], wdata_in[XLEN], we_in, re_in, rd_in[4:0], reg_we_in  in  sideband, passed to the matching *_out.
- out_valid / out_ready  out / in  1 / 1  downstream handshake.
- alu_result  out  XLEN  registered result.
- alu_unknown_op  out  1  registered, qualified by out_valid.
- addr_out  out  XLEN  redirect target.
- addr_out_en  out  1  one-cycle redirect strobe.
- mem_to_reg_out, bytes_out, wdata_out, we_out, re_out, rd_out, reg_we_out, unsigned_flag_out  out  registered sideband.

## Operation
- States: RUN, MULDIV, FLUSH.
- Accept = in_valid && in_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- RUN, accepting a non-muldiv op: register alu result, target and sideband; out_valid=1 next cycle.
- Redirect = jal_en | jalr_en | (branch_en && alu_r[0]).
  - jal / branch target: pc+imm_value, modulo 2^XLEN.
  - jalr target: alu_r & ~1.
- Redirect with FLUSH_CYCLES>0: addr_out_en=1 for exactly the cycle after accept, then state→FLUSH.
  - FLUSH counter loads FLUSH_CYCLES-1 and decrements every cycle regardless of out_ready.
  - FLUSH→RUN when counter==0.
  - FLUSH_CYCLES=0: strobe only, stay in RUN.
- Accepting a muldiv op: latch operands, →MULDIV.
  - XLEN shift-add iterations; 2·XLEN-bit unsigned product.
  - MUL returns the low XLEN bits; MULHU returns the high XLEN bits.
  - On completion, register the result, out_valid=1, →RUN.
  - Muldiv ops never redirect.
- Any other alu_op with muldiv_en=1: alu_unknown_op=1, result 0, single cycle.
- While out_valid && !out_ready, every output holds stable. addr_out_en is never gated by out_ready.
- Reset (low) at any point: state=RUN; out_valid, addr_out_en, alu_unknown_op, we_out, re_out, reg_we_out and all data outputs =0. An in-flight MULDIV is aborted and discarded.

## Timing
- ALU op: accept in cycle N → out_valid in cycle N+1.
- Muldiv op: accept in cycle N → out_valid in cycle N+XLEN+1; in_ready=0 in cycles N+1..N+XLEN.
- Redirect accepted in cycle N: addr_out_en=1 in cycle N+1; in_ready=0 in cycles N+1..N+FLUSH_CYCLES; in_ready may be 1 again from cycle N+FLUSH_CYCLES+1.
- Throughput: one ALU op per cycle with out_ready tied high.
- out_valid falls the cycle after a handshake with no new accept.

## Configuration
- EXEC_STAGE_MULDIV_EN defined: MULDIV state and the iterative multiplier are compiled in.
- Undefined: muldiv_en=1 behaves like an unknown op (alu_unknown_op=1, result 0, one cycle); the MULDIV state does not exist.

## Structure
- exec_pkg holds:
  - alu_op_t encoding;
  - MULDIV_MUL=0, MULDIV_MULHU=1;
  - the state_t enum;
  - FLUSH counter width 3.
- Sub-module exec_muldiv: iterative multiplier with start/done handshake, instantiated only under EXEC_STAGE_MULDIV_EN.
- The existing alu and addr_calc blocks are reused, widened to XLEN.

## Test plan
- Back-to-back ADD ops 5+7, 1+2, out_ready=1 → results 12 and 3 on consecutive cycles; in_ready stays 1.
- jal with pc=0x100, imm=0x20, FLUSH_CYCLES=2 → addr_out=0x120 with addr_out_en high for 1 cycle; in_ready low for exactly 2 cycles.
- out_ready=0 for 3 cycles with a result pending → outputs stable, in_ready=0; result completes on release.
- MUL 0xFFFFFFFF×2, XLEN=32 → 0xFFFFFFFE after 33 cycles. MULHU of the same operands → 0x00000001.
- Reset asserted mid-MULDIV → next cycle out_valid=0, state RUN; the following ADD completes normally.
- Macro undefined, muldiv_en=1 → alu_unknown_op=1, result 0, latency 1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes, multiply selectors,
// FSM states and the flush counter width.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8,
        ALU_EQ  = 4'd9,
        ALU_NE  = 4'd10,
        ALU_GE  = 4'd11
    } alu_op_t;

    // With muldiv_en set, alu_op is reinterpreted as a multiply selector.
    localparam logic [3:0] MULDIV_MUL   = 4'd0;
    localparam logic [3:0] MULDIV_MULHU = 4'd1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1
`ifdef EXEC_STAGE_MULDIV_EN
        ,
        ST_MULDIV = 2'd2
`endif
    } state_t;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/exec_muldiv.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// o_done is high during the final iteration with the full product on o_product.
module exec_muldiv #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic              o_done,
    output logic [2*XLEN-1:0] o_product
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_p_nxt;

    // Upper half accumulates the multiplicand, the whole register shifts right;
    // the multiplier bits drain out of the lower half as the product fills in.
    assign w_sum     = {1'b0, r_p[2*XLEN-1:XLEN]} + {1'b0, r_mcand & {XLEN{r_p[0]}}};
    assign w_p_nxt   = {w_sum, r_p[XLEN-1:1]};
    assign o_done    = (r_cnt == CW'(1));
    assign o_product = w_p_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_p     <= '0;
        end else if (i_start) begin
            r_cnt   <= CW'(XLEN);
            r_mcand <= i_a;
            r_p     <= {{XLEN{1'b0}}, i_b};
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - 1'b1;
            r_p     <= w_p_nxt;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, branch/jump target, redirect flush window, and an
// iterative multiplier compiled in only when EXEC_STAGE_MULDIV_EN is defined.
module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_value,
    input  logic            branch_en,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic            unsigned_flag,
    input  logic            muldiv_en,
    input  logic            mem_to_reg_in,
    input  logic [1:0]      bytes_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic            we_in,
    input  logic            re_in,
    input  logic [4:0]      rd_in,
    input  logic            reg_we_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_unknown_op,
    output logic [XLEN-1:0] addr_out,
    output logic            addr_out_en,
    output logic            mem_to_reg_out,
    output logic [1:0]      bytes_out,
    output logic [XLEN-1:0] wdata_out,
    output logic            we_out,
    output logic            re_out,
    output logic [4:0]      rd_out,
    output logic            reg_we_out,
    output logic            unsigned_flag_out,
    output logic [1:0]      o_dbg_state
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
        FLUSH_CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    state_t                 r_state, w_state_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic                   r_out_valid, r_unknown, r_addr_out_en;
    logic [XLEN-1:0]        r_alu_result, r_addr_out, r_wdata;
    logic                   r_mem_to_reg, r_we, r_re, r_reg_we, r_unsigned;
    logic [1:0]             r_bytes;
    logic [4:0]             r_rd;
    logic                   w_accept, w_redirect, w_is_mul, w_unknown;
    logic                   w_alu_unknown, w_lt;
    logic [XLEN-1:0]        w_alu_r, w_target;

    // Valid/ready: a transfer occurs on a rising edge where valid and ready are
    // both high; while valid waits for ready, valid and its payload hold stable.
    assign in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_lt = unsigned_flag ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));

    always_comb begin
        w_alu_r       = '0;
        w_alu_unknown = 1'b0;
        case (alu_op)
            ALU_ADD: w_alu_r = alu_a + alu_b;
            ALU_SUB: w_alu_r = alu_a - alu_b;
            ALU_AND: w_alu_r = alu_a & alu_b;
            ALU_OR:  w_alu_r = alu_a | alu_b;
            ALU_XOR: w_alu_r = alu_a ^ alu_b;
            ALU_SLL: w_alu_r = alu_a << alu_b[SHW-1:0];
            ALU_SRL: w_alu_r = alu_a >> alu_b[SHW-1:0];
            ALU_SRA: w_alu_r = XLEN'($signed(alu_a) >>> alu_b[SHW-1:0]);
            ALU_SLT: w_alu_r = {{(XLEN-1){1'b0}}, w_lt};
            ALU_EQ:  w_alu_r = {{(XLEN-1){1'b0}}, alu_a == alu_b};
            ALU_NE:  w_alu_r = {{(XLEN-1){1'b0}}, alu_a != alu_b};
            ALU_GE:  w_alu_r = {{(XLEN-1){1'b0}}, !w_lt};
            default: w_alu_unknown = 1'b1;
        endcase
    end

    assign w_unknown  = muldiv_en ? !w_is_mul : w_alu_unknown;
    assign w_redirect = !muldiv_en && (jal_en || jalr_en || (branch_en && w_alu_r[0]));
    assign w_target   = jalr_en ? {w_alu_r[XLEN-1:1], 1'b0} : (pc + imm_value);

`ifdef EXEC_STAGE_MULDIV_EN
    logic              w_mul_done;
    logic [2*XLEN-1:0] w_mul_product;
    logic              r_mul_hi;

    assign w_is_mul = muldiv_en && (alu_op == MULDIV_MUL || alu_op == MULDIV_MULHU);

    exec_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_accept && w_is_mul),
        .i_a       (alu_a),
        .i_b       (alu_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    always_ff @(posedge clk) begin
        if (!reset)                    r_mul_hi <= 1'b0;
        else if (w_accept && w_is_mul) r_mul_hi <= (alu_op == MULDIV_MULHU);
    end
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_is_mul) begin
`ifdef EXEC_STAGE_MULDIV_EN
                    w_state_nxt = ST_MULDIV;
`endif
                end else if (w_accept && w_redirect && (FLUSH_CYCLES > 0)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: if (r_flush_cnt == '0) w_state_nxt = ST_RUN;
`ifdef EXEC_STAGE_MULDIV_EN
            ST_MULDIV: if (w_mul_done) w_state_nxt = ST_RUN;
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // The flush window runs on its own clock count; downstream backpressure does not extend it.
    always_ff @(posedge clk) begin
        if (!reset)                                r_flush_cnt <= '0;
        else if (w_accept && w_redirect)           r_flush_cnt <= FLUSH_LOAD;
        else if (r_state == ST_FLUSH && r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_alu_result  <= '0;
            r_unknown     <= 1'b0;
            r_addr_out    <= '0;
            r_addr_out_en <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_bytes       <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_re          <= 1'b0;
            r_rd          <= '0;
            r_reg_we      <= 1'b0;
            r_unsigned    <= 1'b0;
        end else begin
            r_addr_out_en <= 1'b0;
            if (w_accept) begin
                r_out_valid  <= !w_is_mul;
                r_alu_result <= w_unknown ? '0 : w_alu_r;
                r_unknown    <= w_unknown;
                r_mem_to_reg <= mem_to_reg_in;
                r_bytes      <= bytes_in;
                r_wdata      <= wdata_in;
                r_we         <= we_in;
                r_re         <= re_in;
                r_rd         <= rd_in;
                r_reg_we     <= reg_we_in;
                r_unsigned   <= unsigned_flag;
                if (w_redirect) begin
                    r_addr_out    <= w_target;
                    r_addr_out_en <= 1'b1;
                end
`ifdef EXEC_STAGE_MULDIV_EN
            end else if (w_mul_done && r_state == ST_MULDIV) begin
                r_out_valid  <= 1'b1;
                r_alu_result <= r_mul_hi ? w_mul_product[2*XLEN-1:XLEN] : w_mul_product[XLEN-1:0];
`endif
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign alu_result        = r_alu_result;
    assign alu_unknown_op    = r_unknown;
    assign addr_out          = r_addr_out;
    assign addr_out_en       = r_addr_out_en;
    assign mem_to_reg_out    = r_mem_to_reg;
    assign bytes_out         = r_bytes;
    assign wdata_out         = r_wdata;
    assign we_out            = r_we;
    assign re_out            = r_re;
    assign rd_out            = r_rd;
    assign reg_we_out        = r_reg_we;
    assign unsigned_flag_out = r_unsigned;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage (XLEN=32, FLUSH_CYCLES=2); the multiply
// section follows whichever EXEC_STAGE_MULDIV_EN build is compiled.
module tb_exec_stage;
  import exec_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            in_valid, in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a, alu_b, pc, imm_value;
  logic            branch_en, jal_en, jalr_en, unsigned_flag, muldiv_en;
  logic            mem_to_reg_in, we_in, re_in, reg_we_in;
  logic [1:0]      bytes_in;
  logic [XLEN-1:0] wdata_in;
  logic [4:0]      rd_in;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] alu_result, addr_out, wdata_out;
  logic            alu_unknown_op, addr_out_en;
  logic            mem_to_reg_out, we_out, re_out, reg_we_out, unsigned_flag_out;
  logic [1:0]      bytes_out;
  logic [4:0]      rd_out;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN:0] exp_q[$];
  logic [XLEN:0] sb_exp;

  exec_stage #(.XLEN(XLEN), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .pc(pc), .imm_value(imm_value),
    .branch_en(branch_en), .jal_en(jal_en), .jalr_en(jalr_en),
    .unsigned_flag(unsigned_flag), .muldiv_en(muldiv_en),
    .mem_to_reg_in(mem_to_reg_in), .bytes_in(bytes_in), .wdata_in(wdata_in),
    .we_in(we_in), .re_in(re_in), .rd_in(rd_in), .reg_we_in(reg_we_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .alu_unknown_op(alu_unknown_op), .addr_out(addr_out), .addr_out_en(addr_out_en),
    .mem_to_reg_out(mem_to_reg_out), .bytes_out(bytes_out), .wdata_out(wdata_out),
    .we_out(we_out), .re_out(re_out), .rd_out(rd_out), .reg_we_out(reg_we_out),
    .unsigned_flag_out(unsigned_flag_out), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] pcv, input logic [XLEN-1:0] immv,
                          input logic br, input logic jl, input logic jr,
                          input logic uns, input logic md);
    in_valid = 1'b1; alu_op = op; alu_a = a; alu_b = b; pc = pcv; imm_value = immv;
    branch_en = br; jal_en = jl; jalr_en = jr; unsigned_flag = uns; muldiv_en = md;
  endtask

  task automatic idle();
    in_valid = 1'b0; branch_en = 1'b0; jal_en = 1'b0; jalr_en = 1'b0; muldiv_en = 1'b0;
  endtask

  task automatic push_exp(input logic unk, input logic [XLEN-1:0] res);
    exp_q.push_back({unk, res});
  endtask

  // scoreboard: every downstream handshake must match the next expected result
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) begin
      chk("sb_output_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        chk("sb_result", {31'd0, alu_unknown_op, alu_result}, 64'(sb_exp));
      end
    end
  end

  initial begin
    int lat;
    int busy_err;
    reset = 1'b0; out_ready = 1'b1;
    idle(); alu_op = 4'd0; alu_a = '0; alu_b = '0; pc = '0; imm_value = '0; unsigned_flag = 1'b0;
    mem_to_reg_in = 1'b0; bytes_in = 2'd0; wdata_in = '0; we_in = 1'b0; re_in = 1'b0;
    rd_in = 5'd0; reg_we_in = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_addr_en", 64'(addr_out_en), 64'd0);
    chk("rst_result", 64'(alu_result), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_RUN));
    reset = 1'b1;

    // back-to-back ADDs with sideband
    mem_to_reg_in = 1'b1; bytes_in = 2'd2; wdata_in = 32'hDEAD_BEEF; we_in = 1'b1; rd_in = 5'd5; reg_we_in = 1'b1;
    drive_op(ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(1'b0, 32'd12);
    chk("b2b_ready0", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_valid0", 64'(out_valid), 64'd1);
    chk("b2b_res0", 64'(alu_result), 64'd12);
    chk("b2b_rd0", 64'(rd_out), 64'd5);
    chk("b2b_wdata0", 64'(wdata_out), 64'hDEAD_BEEF);
    chk("b2b_side0", {60'd0, bytes_out, we_out, unsigned_flag_out}, 64'b1011);
    rd_in = 5'd7; we_in = 1'b0;
    drive_op(ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'd3);
    chk("b2b_ready1", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_res1", 64'(alu_result), 64'd3);
    chk("b2b_rd1", 64'(rd_out), 64'd7);
    idle();
    tick();
    chk("b2b_valid_drop", 64'(out_valid), 64'd0);

    // jal: target pc+imm, two-cycle flush window
    drive_op(ALU_ADD, 32'h100, 32'd4, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'h104);
    tick(); idle();
    chk("jal_strobe", 64'(addr_out_en), 64'd1);
    chk("jal_target", 64'(addr_out), 64'h120);
    chk("jal_ready_n1", 64'(in_ready), 64'd0);
    chk("jal_state", 64'(dbg_state), 64'(ST_FLUSH));
    tick();
    chk("jal_strobe_off", 64'(addr_out_en), 64'd0);
    chk("jal_ready_n2", 64'(in_ready), 64'd0);
    tick();
    chk("jal_ready_back", 64'(in_ready), 64'd1);

    // jalr: target clears bit 0 of the ALU sum
    drive_op(ALU_ADD, 32'h203, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(1'b0, 32'h203);
    tick(); idle();
    chk("jalr_strobe", 64'(addr_out_en), 64'd1);
    chk("jalr_target", 64'(addr_out), 64'h202);
    tick(); tick();
    chk("jalr_ready_back", 64'(in_ready), 64'd1);

    // taken branch with wrapping target, then not-taken branch
    drive_op(ALU_EQ, 32'd9, 32'd9, 32'h40, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'd1);
    tick(); idle();
    chk("br_taken_strobe", 64'(addr_out_en), 64'd1);
    chk("br_taken_target", 64'(addr_out), 64'h30);
    tick(); tick();
    drive_op(ALU_NE, 32'd9, 32'd9, 32'h80, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'd0);
    tick(); idle();
    chk("br_not_taken_strobe", 64'(addr_out_en), 64'd0);
    chk("br_not_taken_ready", 64'(in_ready), 64'd1);
    chk("br_not_taken_addr_hold", 64'(addr_out), 64'h30);

    // signed vs unsigned compare, then an undefined op code
    drive_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'd1);
    tick();
    drive_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(1'b0, 32'd0);
    tick();
    drive_op(4'd14, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 32'd0);
    tick(); idle();
    chk("unk_op_flag", 64'(alu_unknown_op), 64'd1);
    tick();

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    drive_op(ALU_SUB, 32'd10, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'd7);
    tick();
    drive_op(ALU_XOR, 32'hF0, 32'hFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_result_held", 64'(alu_result), 64'd7);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    push_exp(1'b0, 32'h0F);
    tick(); idle();
    chk("bp_next_result", 64'(alu_result), 64'h0F);
    tick();
    chk("bp_valid_drop", 64'(out_valid), 64'd0);

`ifdef EXEC_STAGE_MULDIV_EN
    // MUL / MULHU through the iterative unit
    drive_op(MULDIV_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(1'b0, 32'hFFFF_FFFE);
    tick(); idle();
    lat = 1; busy_err = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_err++;
      tick(); lat++;
    end
    chk("mul_latency", 64'(lat), 64'(XLEN + 1));
    chk("mul_busy_ready", 64'(busy_err), 64'd0);
    chk("mul_result", 64'(alu_result), 64'hFFFF_FFFE);
    drive_op(MULDIV_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(1'b0, 32'd1);
    tick(); idle();
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick(); lat++;
    end
    chk("mulhu_latency", 64'(lat), 64'(XLEN + 1));
    chk("mulhu_result", 64'(alu_result), 64'd1);
    // abort an in-flight multiply with reset
    rd_in = 5'd9;
    drive_op(MULDIV_MUL, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); idle();
    chk("mid_mul_state", 64'(dbg_state), 64'(ST_MULDIV));
    tick(); tick(); tick();
`else
    // multiply not built: behaves as a single-cycle unknown op
    drive_op(MULDIV_MUL, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(1'b1, 32'd0);
    tick(); idle();
    chk("md_latency1_valid", 64'(out_valid), 64'd1);
    chk("md_unknown", 64'(alu_unknown_op), 64'd1);
    chk("md_result_zero", 64'(alu_result), 64'd0);
    tick();
    // reset while a result is pending
    out_ready = 1'b0; rd_in = 5'd9;
    drive_op(ALU_ADD, 32'd8, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
`endif
    reset = 1'b0;
    tick();
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_state", 64'(dbg_state), 64'(ST_RUN));
    chk("rst2_result", 64'(alu_result), 64'd0);
    chk("rst2_rd", 64'(rd_out), 64'd0);
    reset = 1'b1; out_ready = 1'b1;
    drive_op(ALU_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 32'd4);
    tick(); idle();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_result", 64'(alu_result), 64'd4);
    tick(); tick();

    // final report
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
